// File: rtl/sensor_cond_pkg.sv
// sensor_cond_pkg: width helper and timing-constant derivations shared by the sensor conditioner
package sensor_cond_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Bits needed to hold every value in 0..v, never less than one
    function automatic int cnt_w(input int v);
        return (v < 1) ? 1 : clog2(v + 1);
    endfunction

    function automatic int ms_div(input int clk_hz);
        return clk_hz / 1000;
    endfunction

    function automatic int db_ticks(input int clk_hz, input int db_ms);
        return ms_div(clk_hz) * db_ms;
    endfunction

    function automatic int s_to_ms(input int s);
        return s * 1000;
    endfunction

endpackage

// File: rtl/sensor_cond_channel.sv
// sensor_cond_channel: one sensor path from raw pin to qualified event, hold, lockout and count
module sensor_cond_channel
    import sensor_cond_pkg::*;
#(
    parameter int DB_TICKS   = 2_000_000,
    parameter int HD_MS      = 15_000,
    parameter int REFRACT_MS = 500,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sens_raw,
    input  logic             ch_en,
    input  logic             retrig_en,
    input  logic             clr_counts,
    input  logic             ms_tick,
    input  logic             warm_done,
    output logic             active,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] evt_cnt
);
    localparam int DB_W = cnt_w(DB_TICKS);
    localparam int HD_W = cnt_w(HD_MS);
    localparam int RF_W = cnt_w(REFRACT_MS);

    logic            s0, s1, db, db_z, qual;
    logic [DB_W-1:0] db_cnt;
    logic [HD_W-1:0] hold_cnt;
    logic [RF_W-1:0] refr_cnt;

    // A debounced rising edge counts only when warmed up, enabled, out of lockout and not a dropped retrigger
    always_comb qual = db & ~db_z & warm_done & ch_en & (refr_cnt == '0) & ~(active & ~retrig_en);

    // Two-flop synchronizer, then db follows s1 once it has differed for DB_TICKS consecutive cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            s0     <= 1'b0;
            s1     <= 1'b0;
            db     <= 1'b0;
            db_z   <= 1'b0;
            db_cnt <= '0;
        end else begin
            s0   <= sens_raw;
            s1   <= s0;
            db_z <= db;
            if (s1 == db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DB_TICKS - 1)) begin
                db     <= s1;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Hold and lockout timers in ms; a rise reloads both and beats a same-cycle tick
    always_ff @(posedge clk) begin
        if (rst || !ch_en) begin
            active     <= 1'b0;
            rise_pulse <= 1'b0;
            hold_cnt   <= '0;
            refr_cnt   <= '0;
        end else begin
            rise_pulse <= qual;
            if (qual) begin
                active   <= 1'b1;
                hold_cnt <= HD_W'(HD_MS);
                refr_cnt <= RF_W'(REFRACT_MS);
            end else if (ms_tick) begin
                if (active) begin
                    hold_cnt <= hold_cnt - HD_W'(1);
                    if (hold_cnt == HD_W'(1)) active <= 1'b0;
                end
                if (refr_cnt != '0) refr_cnt <= refr_cnt - RF_W'(1);
            end
        end
    end

    // Saturating event count; a clear that coincides with a rise leaves that rise counted
    always_ff @(posedge clk) begin
        if (rst) evt_cnt <= '0;
        else if (clr_counts) evt_cnt <= qual ? CNT_W'(1) : '0;
        else if (qual && evt_cnt != '1) evt_cnt <= evt_cnt + CNT_W'(1);
    end

endmodule

// File: rtl/multi_sensor_conditioner.sv
// multi_sensor_conditioner: N sensor channels sharing a 1 ms timebase and a global warm-up mask
module multi_sensor_conditioner
    import sensor_cond_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CLK_HZ      = 100_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int WARMUP_S    = 30,
    parameter int HOLD_S      = 15,
    parameter int REFRACT_MS  = 500,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       sens_raw,
    input  logic [N_CH-1:0]       ch_en,
    input  logic                  retrig_en,
    input  logic                  clr_counts,
    output logic [N_CH-1:0]       active,
    output logic [N_CH-1:0]       rise_pulse,
    output logic                  any_active,
    output logic                  warm_done,
    output logic [N_CH*CNT_W-1:0] evt_cnt
);
    localparam int MS_DIV   = ms_div(CLK_HZ);
    localparam int DB_TICKS = db_ticks(CLK_HZ, DEBOUNCE_MS);
    localparam int WU_MS    = s_to_ms(WARMUP_S);
    localparam int HD_MS    = s_to_ms(HOLD_S);
    localparam int MS_W     = cnt_w(MS_DIV - 1);
    localparam int WU_W     = cnt_w(WU_MS);

    if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
        $error("multi_sensor_conditioner: N_CH must be 1..16");
    end
    if (CLK_HZ % 1000 != 0 || MS_DIV < 1) begin : g_bad_clk
        $error("multi_sensor_conditioner: CLK_HZ must be a nonzero multiple of 1000");
    end
    if (DB_TICKS < 1) begin : g_bad_db
        $error("multi_sensor_conditioner: debounce window must be at least one cycle");
    end
    if (HOLD_S < 1) begin : g_bad_hold
        $error("multi_sensor_conditioner: HOLD_S must be >= 1");
    end

    logic [MS_W-1:0] ms_cnt;
    logic            ms_tick;
    logic [WU_W-1:0] wu_cnt;

    // Free-running ms divider; the registered tick first fires MS_DIV cycles after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ms_cnt  <= '0;
            ms_tick <= 1'b0;
        end else begin
            ms_tick <= ms_cnt == MS_W'(MS_DIV - 1);
            ms_cnt  <= (ms_cnt == MS_W'(MS_DIV - 1)) ? '0 : ms_cnt + MS_W'(1);
        end
    end

    // Warm-up counts ms ticks up to WU_MS and parks there until the next reset
    always_ff @(posedge clk) begin
        if (rst) wu_cnt <= '0;
        else if (ms_tick && wu_cnt != WU_W'(WU_MS)) wu_cnt <= wu_cnt + WU_W'(1);
    end

    assign warm_done  = wu_cnt == WU_W'(WU_MS);
    assign any_active = |active;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        sensor_cond_channel #(
            .DB_TICKS  (DB_TICKS),
            .HD_MS     (HD_MS),
            .REFRACT_MS(REFRACT_MS),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .sens_raw  (sens_raw[i]),
            .ch_en     (ch_en[i]),
            .retrig_en (retrig_en),
            .clr_counts(clr_counts),
            .ms_tick   (ms_tick),
            .warm_done (warm_done),
            .active    (active[i]),
            .rise_pulse(rise_pulse[i]),
            .evt_cnt   (evt_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_multi_sensor_conditioner.sv
// tb_multi_sensor_conditioner: randomized stimulus checked by a timestamp-based model through an output-change scoreboard
module tb_multi_sensor_conditioner;
    localparam int N_CH = 2, CLK_HZ = 10_000, DEBOUNCE_MS = 1, WARMUP_S = 1, HOLD_S = 1, REFRACT_MS = 50, CNT_W = 4;
    localparam int MS_DIV = CLK_HZ / 1000;
    localparam int DB = MS_DIV * DEBOUNCE_MS;
    localparam int WU = WARMUP_S * 1000;
    localparam int HD = HOLD_S * 1000;
    localparam int CMAX = (1 << CNT_W) - 1;
    localparam int VW = 2 + 2 * N_CH + N_CH * CNT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N_CH-1:0] sens_raw = '0;
    logic [N_CH-1:0] ch_en = '1;
    logic retrig_en = 1'b1;
    logic clr_counts = 1'b0;
    logic [N_CH-1:0] active, rise_pulse;
    logic any_active, warm_done;
    logic [N_CH*CNT_W-1:0] evt_cnt;

    typedef struct {
        int cyc;
        logic [VW-1:0] v;
    } obs_t;

    obs_t exp_q[$];
    int cyc = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multi_sensor_conditioner #(
        .N_CH(N_CH), .CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS), .WARMUP_S(WARMUP_S),
        .HOLD_S(HOLD_S), .REFRACT_MS(REFRACT_MS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .sens_raw(sens_raw), .ch_en(ch_en), .retrig_en(retrig_en),
        .clr_counts(clr_counts), .active(active), .rise_pulse(rise_pulse),
        .any_active(any_active), .warm_done(warm_done), .evt_cnt(evt_cnt)
    );

    // Reference model: time is kept as ms ticks elapsed; hold and lockout are end timestamps
    initial begin : model
        int n, tk, tick;
        logic s0 [N_CH];
        logic s1 [N_CH];
        logic lvl [N_CH];
        logic db [N_CH];
        logic dbz [N_CH];
        logic rp [N_CH];
        int run [N_CH];
        int act_end [N_CH];
        int refr_end [N_CH];
        int cnt [N_CH];
        logic q, warm;
        logic [VW-1:0] v, last_v;
        bit first;
        first = 1'b1;
        last_v = '0;
        n = 0;
        tk = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                n = 0;
                tk = 0;
                for (int i = 0; i < N_CH; i++) begin
                    s0[i] = 0; s1[i] = 0; lvl[i] = 0; db[i] = 0; dbz[i] = 0; rp[i] = 0;
                    run[i] = 0; act_end[i] = 0; refr_end[i] = 0; cnt[i] = 0;
                end
            end else begin
                tick = (n > 0 && n % MS_DIV == 0) ? 1 : 0;
                warm = tk >= WU;
                for (int i = 0; i < N_CH; i++) begin
                    q = db[i] && !dbz[i] && warm && ch_en[i] && (tk >= refr_end[i])
                        && !((tk < act_end[i]) && !retrig_en);
                    if (!ch_en[i]) begin
                        act_end[i] = 0;
                        refr_end[i] = 0;
                    end else if (q) begin
                        act_end[i] = tk + tick + HD;
                        refr_end[i] = tk + tick + REFRACT_MS;
                    end
                    if (clr_counts) cnt[i] = q ? 1 : 0;
                    else if (q && cnt[i] < CMAX) cnt[i]++;
                    rp[i] = q;
                    dbz[i] = db[i];
                    run[i] = (s1[i] == lvl[i]) ? run[i] + 1 : 1;
                    lvl[i] = s1[i];
                    if (s1[i] != db[i] && run[i] >= DB) db[i] = s1[i];
                    s1[i] = s0[i];
                    s0[i] = sens_raw[i];
                end
                tk += tick;
                n++;
            end
            v = '0;
            v[VW-1] = tk >= WU;
            for (int i = 0; i < N_CH; i++) begin
                v[N_CH*CNT_W + N_CH + i] = tk < act_end[i];
                v[VW-2] = v[VW-2] | (tk < act_end[i]);
                v[N_CH*CNT_W + i] = rp[i];
                v[i*CNT_W +: CNT_W] = CNT_W'(cnt[i]);
            end
            if (first || v !== last_v) exp_q.push_back('{cyc, v});
            first = 1'b0;
            last_v = v;
        end
    end

    // Monitor: every change on the DUT outputs must match the next predicted change, in cycle and value
    initial begin : monitor
        logic [VW-1:0] d, last_d;
        bit first;
        obs_t e;
        first = 1'b1;
        last_d = '0;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                d = {warm_done, any_active, active, rise_pulse, evt_cnt};
                if (first || d !== last_d) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL output change: cycle %0d value %h, no change predicted", cyc, d);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc != cyc || e.v !== d) begin
                            errors++;
                            $display("FAIL output change: got cycle %0d value %h, expected cycle %0d value %h",
                                     cyc, d, e.cyc, e.v);
                        end
                    end
                end
                first = 1'b0;
                last_d = d;
            end
        end
    end

    task automatic tick_n(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse(input int ch, input int len);
        sens_raw[ch] = 1'b1;
        tick_n(len);
        sens_raw[ch] = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic wait_warm(input string name);
        int k;
        for (k = 0; k < 12000 && !warm_done; k++) @(negedge clk);
        check(name, 32'(warm_done), 32'd1);
    endtask

    initial begin : stim
        int k, len, ch;
        tick_n(5);
        rst = 1'b0;

        // Level held through warm-up gives nothing; a fresh edge afterwards is accepted
        tick_n(95);
        sens_raw[0] = 1'b1;
        wait_warm("warm_done after warm-up");
        tick_n(20);
        sens_raw[0] = 1'b0;
        tick_n(30);
        sens_raw[0] = 1'b1;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rise_pulse[0]) break;
        end
        check("edge to rise_pulse latency", 32'(k), 32'(DB + 3));

        // Short pulse rejected, long one accepted, then a retrigger 200 ms later
        tick_n(50);
        pulse(1, 9);
        tick_n(30);
        len = $urandom_range(40, 12);
        pulse(1, len);
        tick_n(2000 - len);
        len = $urandom_range(40, 12);
        pulse(1, len);
        tick_n(11000);

        // Non-retriggerable: the second edge is dropped and the hold ends on schedule
        retrig_en = 1'b0;
        len = $urandom_range(40, 12);
        pulse(1, len);
        tick_n(2000 - len);
        pulse(1, len);
        tick_n(10500);

        // Lockout: an edge at 20 ms is dropped, one at 60 ms is accepted
        retrig_en = 1'b1;
        sens_raw[0] = 1'b0;
        tick_n(50);
        pulse(0, 15);
        tick_n(185);
        pulse(0, 15);
        tick_n(385);
        pulse(0, 15);
        tick_n(600);

        // Drive the counter into saturation
        for (int i = 0; i < 17; i++) begin
            len = $urandom_range(30, 12);
            pulse(0, len);
            tick_n(600 - len);
        end

        // Clear landing on the same cycle as a qualified rise
        sens_raw[0] = 1'b1;
        tick_n(DB + 2);
        clr_counts = 1'b1;
        tick_n(1);
        clr_counts = 1'b0;
        tick_n(2);
        check("evt_cnt0 after clear with rise", 32'(evt_cnt[CNT_W-1:0]), 32'd1);
        check("evt_cnt1 after clear", 32'(evt_cnt[2*CNT_W-1:CNT_W]), 32'd0);

        // Disabling mid-hold drops active on the next cycle; re-enabling with db high gives no event
        tick_n(1000);
        ch_en[0] = 1'b0;
        tick_n(1);
        check("active0 after ch_en drop", 32'(active[0]), 32'd0);
        tick_n(20);
        ch_en[0] = 1'b1;
        tick_n(100);
        sens_raw[0] = 1'b0;

        // Reset mid-hold clears everything and restarts warm-up
        pulse(1, 20);
        tick_n(3000);
        rst = 1'b1;
        tick_n(1);
        check("outputs after mid-run reset", 32'({warm_done, any_active, active, rise_pulse, evt_cnt}), 32'd0);
        tick_n(2);
        rst = 1'b0;
        tick_n(3000);
        pulse(1, 20);
        wait_warm("warm_done after reset");

        // Random toggling with occasional clears, enable flips and mode changes
        for (int i = 0; i < 300; i++) begin
            ch = $urandom_range(N_CH - 1, 0);
            sens_raw[ch] = ~sens_raw[ch];
            if ($urandom_range(49, 0) == 0) clr_counts = 1'b1;
            if ($urandom_range(29, 0) == 0) begin
                ch = $urandom_range(N_CH - 1, 0);
                ch_en[ch] = ~ch_en[ch];
            end
            if ($urandom_range(19, 0) == 0) retrig_en = ~retrig_en;
            tick_n(1);
            clr_counts = 1'b0;
            tick_n($urandom_range(24, 0));
        end
        ch_en = '1;
        tick_n(50);

        check("predicted changes left unseen", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_sensor_conditioner.md
Name: multi_sensor_conditioner

Overview:
N-channel successor to the single-PIR conditioner. Each channel has a 2-FF synchronizer, debounce, refractory lockout, retriggerable or non-retriggerable hold, and a saturating event counter. All channels share one 1 ms timebase and one warm-up mask. The block sits between the board sensor inputs (PIR, door contacts, etc.) and the fan/lighting control FSMs and event logger.

Parameters:
N_CH, 4, number of sensor channels (1..16)
CLK_HZ, 100_000_000, clk frequency in Hz; must be a multiple of 1000
DEBOUNCE_MS, 20, stability window in ms; DB_TICKS = (CLK_HZ/1000)*DEBOUNCE_MS, must be >= 1
WARMUP_S, 30, global warm-up mask in s; 0 = no mask
HOLD_S, 15, active hold in s; HD_MS = HOLD_S*1000; must be >= 1 (elaboration error otherwise)
REFRACT_MS, 500, per-channel lockout after an accepted event, in ms; 0 = disabled
CNT_W, 16, event counter width per channel

Ports:
clk  in  1  fabric clock
rst  in  1  synchronous, active-high reset
sens_raw  in  N_CH  asynchronous sensor levels, active-high
ch_en  in  N_CH  per-channel enable, synchronous to clk
retrig_en  in  1  1 = a rise during hold reloads the hold; 0 = rises during hold are dropped
clr_counts  in  1  1-cycle strobe that clears all event counters
active  out  N_CH  per-channel "recent event" level
rise_pulse  out  N_CH  1-cycle strobe per accepted event
any_active  out  1  OR of active
warm_done  out  1  warm-up complete
evt_cnt  out  N_CH*CNT_W  saturating event counts; channel i occupies bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset state: all outputs 0, except warm_done = 1 when WARMUP_S = 0. Synchronizers, debounced levels, edge registers, all counters and the timebase clear. Reset mid-operation aborts hold and refractory, and the warm-up period restarts.
- Synchronizer: two flops per channel, reset to 0.
- Debounce, per channel:
  - If s1 == db, the counter clears.
  - Otherwise the counter increments. When it equals DB_TICKS-1 while still differing, db <= s1 and the counter clears.
  - Latency from a sens_raw edge to db is DB_TICKS+2 cycles; to rise_pulse it is DB_TICKS+3 cycles.
  - A level held for fewer than DB_TICKS cycles at s1 is rejected.
- Timebase: ms_tick is a 1-cycle pulse every MS_DIV = CLK_HZ/1000 cycles. The first tick occurs MS_DIV cycles after rst deasserts.
- Warm-up:
  - Counts ms_ticks up to WU_MS = WARMUP_S*1000 and then saturates.
  - warm_done = (count >= WU_MS) and stays high until rst.
  - db continues to track during warm-up. A level already high when warm-up ends produces no event; a new rising edge is required.
- Qualified rise for channel i, all of the following must hold:
  - db rising edge (db & ~db_z)
  - warm_done
  - ch_en[i]
  - the channel is not in refractory
  - not (active[i] and retrig_en = 0)
- On a qualified rise:
  - rise_pulse[i] = 1 for the next cycle.
  - active[i] = 1 and hold_cnt = HD_MS.
  - refr_cnt = REFRACT_MS.
  - evt_cnt[i] increments, saturating at 2^CNT_W-1.
- Hold countdown: on each ms_tick with active[i] = 1 and no rise, hold_cnt decrements. On the tick where hold_cnt == 1, active clears. Active therefore spans exactly HD_MS ticks after the last accepted rise.
- Refractory: refr_cnt decrements on ms_tick while nonzero. The channel is in refractory while refr_cnt != 0.
- Simultaneous events:
  - A rise and an ms_tick in the same cycle: the rise wins (reload, no decrement).
  - clr_counts together with a rise: the counter becomes 1. With no rise it becomes 0. Clearing affects all channels.
- ch_en[i] low: active[i], hold_cnt and refr_cnt clear on the next cycle, and no rise_pulse is issued. The counter value is kept. Debounce keeps running, so re-enabling while db = 1 produces no event.
- any_active: combinational OR of the registered active bits.

Decomposition:
- Package sensor_cond_pkg holds:
  - the clog2 function
  - derived constants: MS_DIV, DB_TICKS, WU_MS, HD_MS and their widths
- Sub-module sensor_cond_channel contains sync, debounce, edge detection, refractory, hold and counter. It takes ms_tick and warm_done as inputs and is instantiated N_CH times via generate.
- The top level owns the timebase, the warm-up counter, any_active and evt_cnt packing.

Test Plan (N_CH=2, CLK_HZ=10_000, DEBOUNCE_MS=1 so DB_TICKS=10, WARMUP_S=1, HOLD_S=1, REFRACT_MS=50, CNT_W=4; ms_tick every 10 cycles):
1. Raw0 high from cycle 100 through the end of warm-up -> warm_done rises at about cycle 10_000; no rise_pulse, active0 = 0, evt_cnt0 = 0. Then low 30 cycles and high again -> rise_pulse0 exactly 13 cycles after the edge.
2. Post warm-up, raw1 high for 9 cycles -> no event. Raw1 high for 12 cycles -> one rise_pulse1, active1 high for exactly 1000 ms_ticks (10_000 cycles ±10), evt_cnt1 = 1.
3. retrig_en = 1: second edge 200 ms after the first -> second pulse, active extends to 1000 ticks after the second rise. retrig_en = 0: same stimulus -> no pulse, count unchanged, active ends 1000 ticks after the first rise.
4. Retrig mode, second edge 20 ms after the first (inside REFRACT_MS) -> dropped. Edge at 60 ms -> accepted, count = 2.
5. Drive 17 events on ch0 -> evt_cnt0 saturates at 15. clr_counts coincident with a rise on ch0 -> evt_cnt0 = 1, evt_cnt1 = 0. ch_en0 dropped mid-hold -> active0 = 0 the next cycle.
6. rst asserted mid-hold -> all outputs 0 the next cycle; warm_done stays low for another 1000 ticks; an edge during that time yields no event.
